piso_tx_arbiter: RTL and testbench

PISO_TX_ARBITER -- requirements
Module: piso_tx_arbiter

---
 rtl/piso_tx_arbiter.sv | 120 ++++++++++++
 tb/tb_piso_tx_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a parallel-in, serial-out transmitter.
// Bytes go out MSB first, optionally followed by a fixed number of idle cycles.
module piso_tx_arbiter #(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic [DATA_W:1] din0,
  input  logic            req1,
  input  logic [DATA_W:1] din1,
  input  logic            flush,
  output logic            ack0,
  output logic            ack1,
  output logic            q,
  output logic            valid,
  output logic            src,
  output logic            busy
);

  localparam int CNT_MAX = (DATA_W > GAP) ? DATA_W : GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t          state, state_n;
  logic [DATA_W:1] sreg, sreg_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            ptr, ptr_n;
  logic            src_n, ack0_n, ack1_n, q_n, valid_n, busy_n;
  logic            pending, winner, capture;

  assign pending = req0 | req1;
  // On contention the requester that was not served last wins; a lone request always wins.
  assign winner  = (req0 & req1) ? ~ptr : req1;

  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    ptr_n   = ptr;
    src_n   = src;
    capture = 1'b0;
    case (state)
      S_IDLE: begin
        if (!flush && pending) capture = 1'b1;
      end
      S_SHIFT: begin
        if (flush) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          sreg_n = sreg << 1;
          cnt_n  = cnt + 1'b1;
          if (cnt == CW'(DATA_W - 1)) begin
            cnt_n = '0;
            if (GAP > 0)      state_n = S_GAP;
            else if (pending) capture = 1'b1;
            else              state_n = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (flush || cnt == CW'(GAP - 1)) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase

    // A capture (from IDLE or the back-to-back last-bit edge) overrides the shift.
    if (capture) begin
      sreg_n  = winner ? din1 : din0;
      cnt_n   = '0;
      ptr_n   = winner;
      src_n   = winner;
      state_n = S_SHIFT;
    end

    ack0_n  = capture & ~winner;
    ack1_n  = capture & winner;
    valid_n = (state_n == S_SHIFT);
    q_n     = valid_n & sreg_n[DATA_W];
    busy_n  = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      ptr   <= 1'b1;
      src   <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      q     <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
      ptr   <= ptr_n;
      src   <= src_n;
      ack0  <= ack0_n;
      ack1  <= ack1_n;
      q     <= q_n;
      valid <= valid_n;
      busy  <= busy_n;
    end
  end

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Bench for piso_tx_arbiter: a GAP=1 and a GAP=0 instance, directed vectors,
// every cycle compared against a frame-schedule model plus hand-computed literals.
module tb_piso_tx_arbiter;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req0, req1, flush;
  logic [DW:1] din0 [2];
  logic [DW:1] din1 [2];
  logic [1:0]  ack0, ack1, q, valid, src, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piso_tx_arbiter #(.DATA_W(DW), .GAP(1)) dut_g1 (
    .clk(clk), .reset(rst_n), .req0(req0[0]), .din0(din0[0]), .req1(req1[0]), .din1(din1[0]),
    .flush(flush[0]), .ack0(ack0[0]), .ack1(ack1[0]), .q(q[0]), .valid(valid[0]),
    .src(src[0]), .busy(busy[0]));

  piso_tx_arbiter #(.DATA_W(DW), .GAP(0)) dut_g0 (
    .clk(clk), .reset(rst_n), .req0(req0[1]), .din0(din0[1]), .req1(req1[1]), .din1(din1[1]),
    .flush(flush[1]), .ack0(ack0[1]), .ack1(ack1[1]), .q(q[1]), .valid(valid[1]),
    .src(src[1]), .busy(busy[1]));

  // Model: a capture schedules the whole frame as a queue of per-cycle outputs
  // (DW data slots then GAP idle slots); the queue head is what must be shown now.
  // Slot encoding: 2 + bit for a data slot, 0 for an idle gap slot.
  int         sched [2][$];
  logic [1:0] m_ptr, m_src, m_ack0, m_ack1;

  function automatic int gap_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) sched[i].delete();
    m_ptr  = 2'b11;
    m_src  = 2'b00;
    m_ack0 = 2'b00;
    m_ack1 = 2'b00;
  endtask

  task automatic model_step();
    logic       idle_before, w;
    logic [DW:1] d;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        idle_before = (sched[i].size() == 0);
        m_ack0[i] = 1'b0;
        m_ack1[i] = 1'b0;
        if (flush[i]) begin
          sched[i].delete();
        end else begin
          if (!idle_before) void'(sched[i].pop_front());
          if ((req0[i] || req1[i]) && sched[i].size() == 0 &&
              (idle_before || gap_of(i) == 0)) begin
            w = (req0[i] && req1[i]) ? ~m_ptr[i] : req1[i];
            d = w ? din1[i] : din0[i];
            for (int b = DW; b >= 1; b--) sched[i].push_back(2 + int'(d[b]));
            for (int g = 0; g < gap_of(i); g++) sched[i].push_back(0);
            m_ptr[i] = w;
            m_src[i] = w;
            if (w) m_ack1[i] = 1'b1;
            else   m_ack0[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [5:0] act, exp;
    logic       hv, hq;
    for (int i = 0; i < 2; i++) begin
      hv = 1'b0;
      hq = 1'b0;
      if (sched[i].size() > 0) begin
        hv = (sched[i][0] >= 2);
        hq = (sched[i][0] == 3);
      end
      exp = {m_ack0[i], m_ack1[i], hq, hv, m_src[i], sched[i].size() > 0};
      act = {ack0[i], ack1[i], q[i], valid[i], src[i], busy[i]};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_dut%0d t=%0t got {ack0,ack1,q,valid,src,busy}=%b want %b",
                 i, $time, act, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(input int i, input int budget);
    int c = 0;
    while (!(ack0[i] | ack1[i]) && c < budget) begin
      tick();
      c++;
    end
    lit("ack_seen", ack0[i] | ack1[i], 1);
  endtask

  task automatic frame_bits(input int i, output logic [DW:1] b);
    b = '0;
    for (int k = 0; k < DW; k++) begin
      b = {b[DW-1:1], q[i]};
      tick();
    end
  endtask

  initial begin
    logic [DW:1] bits;
    logic [15:0] bits16;
    int n, acks, found, extra;

    rst_n = 1'b0;
    req0  = '0;
    req1  = '0;
    flush = '0;
    for (int i = 0; i < 2; i++) begin
      din0[i] = '0;
      din1[i] = '0;
    end
    model_reset();
    tick();
    tick();
    lit("reset_outputs", {ack0, ack1, q, valid, src, busy}, 0);
    rst_n = 1'b1;

    // Both held: frames alternate 0,1,0,1 from requester 0.
    req0[0] = 1'b1; req1[0] = 1'b1; din0[0] = 8'hAA; din1[0] = 8'h55;
    for (int f = 0; f < 4; f++) begin
      wait_ack(0, 24);
      lit("alt_src", src[0], f % 2);
      lit("alt_ack0", ack0[0], (f % 2 == 0));
      frame_bits(0, bits);
      lit("alt_byte", bits, (f % 2) ? 8'h55 : 8'hAA);
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    tick();

    // Single byte, bit order and one gap cycle.
    req0[0] = 1'b1; din0[0] = 8'b1010_0001;
    wait_ack(0, 4);
    lit("r31_ack0", ack0[0], 1);
    lit("r31_src", src[0], 0);
    req0[0] = 1'b0;
    frame_bits(0, bits);
    lit("r31_bits", bits, 8'b1010_0001);
    lit("r31_gap", {valid[0], q[0], busy[0]}, 3'b001);
    tick();
    lit("r31_idle", busy[0], 0);

    // Flush on the 4th shift cycle.
    req0[0] = 1'b1; din0[0] = 8'hFF;
    wait_ack(0, 4);
    req0[0] = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      n += int'(valid[0] & q[0]);
      if (k == 3) flush[0] = 1'b1;
      tick();
    end
    flush[0] = 1'b0;
    lit("flush_ones", n, 4);
    lit("flush_idle", {valid[0], busy[0]}, 0);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      extra += int'(ack0[0]) + int'(ack1[0]) + int'(valid[0]);
      tick();
    end
    lit("flush_no_more", extra, 0);

    // Flush in IDLE beats a pending request.
    req1[0] = 1'b1; din1[0] = 8'h3C; flush[0] = 1'b1;
    tick();
    lit("idle_flush_noack", {ack1[0], busy[0]}, 0);
    flush[0] = 1'b0;
    tick();
    lit("after_flush_ack1", ack1[0], 1);
    req1[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    // One-cycle pulse is captured; a request raised mid-frame waits for IDLE.
    req0[0] = 1'b1; din0[0] = 8'h81;
    tick();
    req0[0] = 1'b0;
    lit("pulse_ack0", ack0[0], 1);
    found = -1;
    for (int k = 0; k < 14; k++) begin
      if (k == 2) begin req0[0] = 1'b1; din0[0] = 8'h7E; end
      if (k > 0 && ack0[0] && found < 0) begin found = k; req0[0] = 1'b0; end
      tick();
    end
    lit("late_req_ack_cycle", found, 10);
    for (int k = 0; k < 8; k++) tick();

    // GAP=0 back-to-back frames with continuous valid.
    req1[1] = 1'b1; din1[1] = 8'hC3;
    wait_ack(1, 4);
    n = 0; acks = 0; bits16 = '0;
    for (int k = 0; k < 2 * DW; k++) begin
      n += int'(valid[1]);
      bits16 = {bits16[14:0], q[1]};
      if (ack1[1]) begin
        acks++;
        if (acks == 1) din1[1] = 8'h5A;
        else           req1[1] = 1'b0;
      end
      tick();
    end
    lit("b2b_valid_run", n, 16);
    lit("b2b_bits", bits16, 16'hC35A);
    lit("b2b_acks", acks, 2);
    lit("b2b_idle", {valid[1], busy[1]}, 0);

    // Asynchronous reset mid-frame, then service order after release.
    req0[0] = 1'b1; din0[0] = 8'hF0;
    wait_ack(0, 4);
    req0[0] = 1'b0;
    tick();
    tick();
    @(posedge clk);
    model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    lit("async_rst", {q[0], valid[0], busy[0]}, 0);
    @(negedge clk);
    compare();
    req1[0] = 1'b1; din1[0] = 8'h99; rst_n = 1'b1;
    tick();
    lit("rst_req1_first", {ack1[0], src[0]}, 2'b11);
    req1[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    model_reset();
    tick();
    req0[0] = 1'b1; req1[0] = 1'b1; din0[0] = 8'h12; din1[0] = 8'h34; rst_n = 1'b1;
    tick();
    lit("rst_both_req0", {ack0[0], ack1[0], src[0]}, 3'b100);
    req0[0] = 1'b0; req1[0] = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
